// File: rtl/buffer_tile_packer.sv
// buffer_tile_packer
//   Write-side producer for buffer_file. It takes a byte-lane element stream
//   (valid/ready) and packs it into TILE_WIDTH tiles. Each command fills exactly
//   one buffer with TILE_COUNT tile writes. Elements past the requested count
//   are written as zero.
//
// Ports
//   clk, reset_n   clock (rising edge) and asynchronous active-low reset
//   start          command strobe, sampled only in IDLE
//   start_buffer   target buffer id for the command
//   start_count    number of valid elements; clamped to MAX_ELEMS
//   busy           high from the cycle after an accepted start through the done cycle
//   in_valid/in_ready/in_data
//                  element beat stream; lane j holds element beat*IN_BYTES+j
//   write_enable   one-cycle tile write strobe to buffer_file
//   write_data     tile payload; element k sits at bits k*DATA_WIDTH +: DATA_WIDTH
//   write_buffer   buffer id latched at start
//   writing_done   buffer_file pulse after the final tile write
//   done           one-cycle pulse once the buffer is fully written
//
// States
//   state     | meaning
//   IDLE      | waiting for start
//   FILL      | gathering beats into the tile accumulator
//   WRITE     | tile strobe on write_enable, accumulator cleared
//   WAIT_DONE | all tiles issued, waiting for writing_done
//   DONE      | done pulse, back to IDLE next cycle

module buffer_tile_packer #(
  parameter int BUFFER_WIDTH = 1024,
  parameter int BUFFER_COUNT = 2,
  parameter int TILE_WIDTH   = 256,
  parameter int DATA_WIDTH   = 8,
  parameter int IN_BYTES     = 8
) (
  input  logic                                               clk,
  input  logic                                               reset_n,
  input  logic                                               start,
  input  logic [$clog2(BUFFER_COUNT)-1:0]                    start_buffer,
  input  logic [$clog2(BUFFER_WIDTH/DATA_WIDTH+1)-1:0]       start_count,
  output logic                                               busy,
  input  logic                                               in_valid,
  output logic                                               in_ready,
  input  logic [IN_BYTES*DATA_WIDTH-1:0]                     in_data,
  output logic                                               write_enable,
  output logic [TILE_WIDTH-1:0]                              write_data,
  output logic [$clog2(BUFFER_COUNT)-1:0]                    write_buffer,
  input  logic                                               writing_done,
  output logic                                               done
);

  localparam int TILE_COUNT     = BUFFER_WIDTH / TILE_WIDTH;
  localparam int EPT            = TILE_WIDTH / DATA_WIDTH;
  localparam int MAX_ELEMS      = BUFFER_WIDTH / DATA_WIDTH;
  localparam int BEAT_W         = IN_BYTES * DATA_WIDTH;
  localparam int BEATS_PER_TILE = EPT / IN_BYTES;
  localparam int CW             = $clog2(MAX_ELEMS + 1);
  localparam int SW             = (BEATS_PER_TILE > 1) ? $clog2(BEATS_PER_TILE) : 1;
  localparam int TW             = (TILE_COUNT > 1) ? $clog2(TILE_COUNT) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FILL      = 3'd1,
    WRITE     = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t                  state;
  logic [CW-1:0]           count_q;
  logic [CW-1:0]           elem_idx;
  logic [TW-1:0]           tile_idx;
  logic [SW-1:0]           beat_slot;
  logic [TILE_WIDTH-1:0]   acc;

  logic [BEAT_W-1:0]       beat_masked;
  logic [TILE_WIDTH-1:0]   acc_merged;
  logic [CW:0]             elem_sum;
  logic [CW-1:0]           elem_next;
  logic                    fill_done;
  logic                    slot_wrap;
  logic                    last_tile;

  // beat_slot tracks the tile offset in beats; since every beat advances
  // elem_idx by IN_BYTES and each tile is flushed when full, it always equals
  // (elem_idx % EPT) / IN_BYTES while elements remain.
  assign fill_done = (elem_idx >= count_q);
  assign slot_wrap = (beat_slot == SW'(BEATS_PER_TILE - 1));
  assign last_tile = (tile_idx == TW'(TILE_COUNT - 1));
  assign in_ready  = (state == FILL) && !fill_done;

  assign elem_sum  = {1'b0, elem_idx} + (CW+1)'(IN_BYTES);
  assign elem_next = (elem_sum >= {1'b0, count_q}) ? count_q : elem_sum[CW-1:0];

  // Lanes whose global element index reaches the count are stored as zero so
  // surplus bytes in the final beat never leak into the buffer.
  always_comb begin
    beat_masked = '0;
    for (int j = 0; j < IN_BYTES; j++) begin
      if (({1'b0, elem_idx} + (CW+1)'(j)) < {1'b0, count_q}) begin
        beat_masked[j*DATA_WIDTH +: DATA_WIDTH] = in_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    acc_merged = acc;
    acc_merged[beat_slot*BEAT_W +: BEAT_W] = beat_masked;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      write_enable <= 1'b0;
      write_data   <= '0;
      write_buffer <= '0;
      done         <= 1'b0;
      count_q      <= '0;
      elem_idx     <= '0;
      tile_idx     <= '0;
      beat_slot    <= '0;
      acc          <= '0;
    end else begin
      write_enable <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            write_buffer <= start_buffer;
            count_q      <= (start_count > CW'(MAX_ELEMS)) ? CW'(MAX_ELEMS) : start_count;
            acc          <= '0;
            elem_idx     <= '0;
            tile_idx     <= '0;
            beat_slot    <= '0;
            busy         <= 1'b1;
            state        <= FILL;
          end
        end

        FILL: begin
          if (fill_done) begin
            // Nothing left to load: emit the (zero) tile right away so the
            // buffer_file tile index still advances once per tile.
            write_enable <= 1'b1;
            write_data   <= acc;
            state        <= WRITE;
          end else if (in_valid) begin
            acc       <= acc_merged;
            elem_idx  <= elem_next;
            beat_slot <= slot_wrap ? '0 : beat_slot + SW'(1);
            if (slot_wrap || (elem_sum >= {1'b0, count_q})) begin
              write_enable <= 1'b1;
              write_data   <= acc_merged;
              state        <= WRITE;
            end
          end
        end

        WRITE: begin
          acc       <= '0;
          beat_slot <= '0;
          tile_idx  <= tile_idx + TW'(1);
          state     <= last_tile ? WAIT_DONE : FILL;
        end

        WAIT_DONE: begin
          if (writing_done) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_tile_packer.sv
// Bench for buffer_tile_packer. Expected tiles are pushed into a scoreboard
// when a command is issued; a negedge monitor pops and compares on every tile
// strobe and also plays the buffer_file side by answering with writing_done.

module tb_buffer_tile_packer;

  localparam int TILES = 4;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [0:0]   start_buffer;
  logic [7:0]   start_count;
  logic         busy;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_data;
  logic         write_enable;
  logic [255:0] write_data;
  logic [0:0]   write_buffer;
  logic         writing_done;
  logic         done;

  buffer_tile_packer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .start_buffer (start_buffer),
    .start_count  (start_count),
    .busy         (busy),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .write_enable (write_enable),
    .write_data   (write_data),
    .write_buffer (write_buffer),
    .writing_done (writing_done),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] data;
    int           tile;
    int           bufid;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] elem [0:159];

  int  n_tests = 0;
  int  n_fail  = 0;
  int  hs_count, wr_count, done_count, ready_cycles;
  bit  wd_req = 0, wd_force = 0;
  bit  prev_wd = 0, prev_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // buffer_file stand-in: answers the last tile strobe with a writing_done pulse
  initial begin
    writing_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      writing_done = wd_req | wd_force;
      wd_req   = 0;
      wd_force = 0;
    end
  end

  always @(negedge clk) begin
    if (in_valid && in_ready) hs_count++;
    if (in_ready) ready_cycles++;
    if (write_enable) begin
      wr_count++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got write %0d expected none", wr_count);
      end else begin
        mon_e = sb.pop_front();
        n_tests++;
        if (write_data !== mon_e.data) begin
          n_fail++;
          $display("FAIL tile%0d_data: got %h expected %h", mon_e.tile, write_data, mon_e.data);
        end
        check("write_buffer", 64'(write_buffer), 64'(mon_e.bufid));
      end
      if (wr_count == TILES) wd_req = 1;
    end
    if (done) begin
      done_count++;
      check("done_after_writing_done", 64'(prev_wd), 64'd1);
      check("done_single_cycle", 64'(prev_done), 64'd0);
    end
    prev_wd   = writing_done;
    prev_done = done;
  end

  task automatic check_reset_outputs(input string name);
    check(name, {59'd0, busy, in_ready, write_enable, done, write_buffer}, 64'd0);
    check({name, "_data"}, 64'(|write_data), 64'd0);
  endtask

  // Issues one command and feeds n_beats beats; called at posedge+1.
  task automatic run_cmd(input int bufid, input int cnt, input int n_beats,
                         input int valid_pct, input int abort_wr, input bit poke_start);
    int   eff, exp_beats, b, cyc, n;
    bit   hs, poked;
    exp_t e;
    eff = (cnt > 128) ? 128 : cnt;
    exp_beats = (eff + 7) / 8;
    if (exp_beats > n_beats) exp_beats = n_beats;
    for (int t = 0; t < TILES; t++) begin
      e.data = '0;
      for (int i = 0; i < 32; i++) begin
        n = t * 32 + i;
        if (n < eff) e.data[i*8 +: 8] = elem[n];
      end
      e.tile  = t;
      e.bufid = bufid;
      sb.push_back(e);
    end
    hs_count = 0; wr_count = 0; done_count = 0; ready_cycles = 0;

    start        = 1'b1;
    start_buffer = 1'(bufid);
    start_count  = 8'(cnt);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);

    b = 0; cyc = 0; poked = 0;
    while (b < n_beats && done_count == 0 && cyc < 400 &&
           !(abort_wr > 0 && wr_count >= abort_wr)) begin
      in_valid = ($urandom_range(99) < valid_pct);
      for (int j = 0; j < 8; j++) in_data[j*8 +: 8] = elem[b*8 + j];
      if (poke_start && b == 3 && !poked) begin
        start        = 1'b1;
        start_buffer = (bufid == 0) ? 1'b1 : 1'b0;
        start_count  = 8'd5;
        poked        = 1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) b++;
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;

    if (abort_wr > 0) begin
      check("abort_point_reached", 64'(wr_count >= abort_wr), 64'd1);
      reset_n = 1'b0;
      #1;
      check_reset_outputs("abort_reset_outputs");
      sb.delete();
      @(posedge clk); #1;
      check_reset_outputs("abort_reset_hold");
      reset_n = 1'b1;
      @(posedge clk); #1;
    end else begin
      cyc = 0;
      while (done_count == 0 && cyc < 100) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("done_seen", 64'(done_count), 64'd1);
      check("beats_accepted", 64'(hs_count), 64'(exp_beats));
      check("tile_writes", 64'(wr_count), 64'(TILES));
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      @(posedge clk); #1;
      check("busy_cleared", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    start        = 1'b0;
    start_buffer = '0;
    start_count  = '0;
    in_valid     = 1'b0;
    in_data      = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_outputs");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // writing_done while idle must not produce done
    done_count = 0;
    @(negedge clk);
    wd_force = 1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_writing_done_ignored", 64'(done_count), 64'd0);
    check("idle_not_busy", 64'(busy), 64'd0);

    // full buffer, element n = n
    for (int i = 0; i < 160; i++) elem[i] = 8'(i);
    run_cmd(1, 128, 16, 100, 0, 0);

    // partial: 5 beats, tile1 bytes 0..7 = 32..39
    run_cmd(0, 40, 8, 100, 0, 0);

    // count=13 with junk in the surplus lanes of the second beat
    for (int i = 0; i < 160; i++) elem[i] = 8'(i + 8'h40);
    elem[13] = 8'hFF; elem[14] = 8'hFF; elem[15] = 8'hFF;
    run_cmd(1, 13, 3, 100, 0, 0);

    // bursty source
    for (int i = 0; i < 160; i++) elem[i] = 8'(i);
    run_cmd(0, 128, 16, 50, 0, 0);

    // oversized count clamps; start while busy ignored
    for (int i = 0; i < 160; i++) elem[i] = 8'(255 - i);
    run_cmd(1, 200, 20, 100, 0, 1);

    // empty command: four zero tiles, never ready
    run_cmd(0, 0, 2, 100, 0, 0);
    check("count0_never_ready", 64'(ready_cycles), 64'd0);

    // abort mid-command, then a clean reload
    for (int i = 0; i < 160; i++) elem[i] = 8'(i) ^ 8'hA5;
    run_cmd(1, 128, 16, 100, 2, 0);
    run_cmd(1, 128, 16, 100, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
